// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S/TDM transmitter and the clock generator.
//   - Default parameter values for the transmitter and clock generator.
//   - frame_bits(): number of SCLK periods in one audio frame.
//   - bit_cnt_t: in-frame bit counter type. It is sized for the largest frame
//     supported (MAX_FRAME_BITS), so one type serves every configuration.
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int DEF_MCLK_DIV   = 8;   // 100 MHz / 8  = 12.5 MHz MCLK
  localparam int DEF_SCLK_RATIO = 4;   // 12.5 MHz / 4 = 3.125 MHz SCLK
  localparam int DEF_DATA_W     = 24;
  localparam int DEF_SLOT_W     = 32;
  localparam int DEF_CHANNELS   = 2;

  // Up to 16 slots of 64 SCLKs.
  localparam int MAX_FRAME_BITS = 1024;
  localparam int BIT_CNT_W      = $clog2(MAX_FRAME_BITS);

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  function automatic int frame_bits(input int channels, input int slot_w);
    return channels * slot_w;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
// Audio clock generator: divides the system clock into MCLK and SCLK and
// flags the system-clock cycle on which SCLK falls.
//
// One prescaler chain drives everything: a half-MCLK counter whose wrap
// toggles MCLK, followed by a ratio counter whose wrap (together with the
// half-MCLK wrap) toggles SCLK. Both outputs are registered.
//
// Ports:
//   clk_i      in   system clock
//   reset_n_i  in   asynchronous reset, active HIGH (legacy name)
//   mclk_o     out  master clock, toggles every MCLK_DIV/2 clk cycles
//   sclk_o     out  bit clock, toggles every SCLK_RATIO*MCLK_DIV/2 clk cycles,
//                   starts low
//   fall_o     out  one-clk strobe, high on the clk edge where sclk_o goes 1->0
// -----------------------------------------------------------------------------
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV   = DEF_MCLK_DIV,
  parameter int SCLK_RATIO = DEF_SCLK_RATIO
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic mclk_o,
  output logic sclk_o,
  output logic fall_o
);

  localparam int HALF_M = MCLK_DIV / 2;
  localparam int MW     = (HALF_M > 1) ? $clog2(HALF_M) : 1;
  localparam int RW     = (SCLK_RATIO > 1) ? $clog2(SCLK_RATIO) : 1;

  typedef logic [MW-1:0] m_cnt_t;
  typedef logic [RW-1:0] r_cnt_t;

  localparam m_cnt_t M_LAST = m_cnt_t'(HALF_M - 1);
  localparam r_cnt_t R_LAST = r_cnt_t'(SCLK_RATIO - 1);

  m_cnt_t m_cnt_q, m_cnt_d;
  r_cnt_t r_cnt_q, r_cnt_d;
  logic   mclk_q, mclk_d;
  logic   sclk_q, sclk_d;
  logic   m_wrap, sclk_tgl;

  always_comb begin
    m_wrap   = (m_cnt_q == M_LAST);
    // SCLK toggles once per SCLK_RATIO MCLK half-periods.
    sclk_tgl = m_wrap && (r_cnt_q == R_LAST);

    m_cnt_d = m_wrap ? '0 : m_cnt_q + m_cnt_t'(1);
    r_cnt_d = r_cnt_q;
    if (m_wrap) begin
      r_cnt_d = (r_cnt_q == R_LAST) ? '0 : r_cnt_q + r_cnt_t'(1);
    end
    mclk_d = mclk_q ^ m_wrap;
    sclk_d = sclk_q ^ sclk_tgl;
  end

  always_ff @(posedge clk_i or posedge reset_n_i) begin
    if (reset_n_i) begin
      m_cnt_q <= '0;
      r_cnt_q <= '0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      m_cnt_q <= m_cnt_d;
      r_cnt_q <= r_cnt_d;
      mclk_q  <= mclk_d;
      sclk_q  <= sclk_d;
    end
  end

  assign mclk_o = mclk_q;
  assign sclk_o = sclk_q;
  // Combinational from registered state: consumers update on this same edge,
  // so data changes together with the SCLK falling edge.
  assign fall_o = sclk_tgl && sclk_q;

endmodule

// File: rtl/i2s_tx_tdm.sv
// -----------------------------------------------------------------------------
// i2s_tx_tdm
// Parametrised I2S (CHANNELS==2) / TDM (CHANNELS>2) transmitter. Takes one
// multi-channel sample frame per audio frame over valid/ready, holds it in a
// one-entry buffer and serialises it MSB-first onto tx_sd.
//
// Build option: macro I2S_TX_LJ_MODE_EN selects left-justified timing (no
// one-bit data delay, stereo word-select high = channel 0, TDM frame sync on
// slot 0's first bit). Undefined gives standard I2S / DSP-A timing.
//
// Ports:
//   clk       in   system clock (100 MHz)
//   reset_n   in   asynchronous reset, active HIGH (legacy name)
//   s_data    in   CHANNELS*DATA_W, channel 0 in the LSBs, two's complement
//   s_valid   in   s_data valid
//   s_ready   out  holding buffer empty
//   tx_mclk   out  master clock
//   tx_sclk   out  bit clock
//   tx_lrclk  out  word select (stereo) / frame sync (TDM)
//   tx_sd     out  serial data
//   underrun  out  one-clk pulse when a frame starts with no buffered sample
//
// Handshake: a transfer happens on every clk edge where s_valid && s_ready.
// s_data is captured on that edge and need not be held; s_ready is low from
// the next clk until the buffer is consumed at the next frame start.
// -----------------------------------------------------------------------------
module i2s_tx_tdm
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV   = DEF_MCLK_DIV,
  parameter int SCLK_RATIO = DEF_SCLK_RATIO,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SLOT_W     = DEF_SLOT_W,
  parameter int CHANNELS   = DEF_CHANNELS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CHANNELS*DATA_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       tx_mclk,
  output logic                       tx_sclk,
  output logic                       tx_lrclk,
  output logic                       tx_sd,
  output logic                       underrun
);

  localparam int F  = frame_bits(CHANNELS, SLOT_W);
  localparam int SW = CHANNELS * DATA_W;

  localparam bit_cnt_t B_LAST = bit_cnt_t'(F - 1);
  localparam bit_cnt_t B_SLOT = bit_cnt_t'(SLOT_W);

  logic fall;

  i2s_clkgen #(
    .MCLK_DIV   (MCLK_DIV),
    .SCLK_RATIO (SCLK_RATIO)
  ) u_clkgen (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .mclk_o    (tx_mclk),
    .sclk_o    (tx_sclk),
    .fall_o    (fall)
  );

  bit_cnt_t        b_q, b_d, b_next;
  logic            lrclk_q, lrclk_d, lr_next;
  logic [F-1:0]    sh_q, sh_d;
  logic [SW-1:0]   buf_q, buf_d;
  logic            full_q, full_d;
  logic            ready_q, ready_d;
  logic            underrun_q, underrun_d;
  logic            wrap, xfer;
  logic [F-1:0]    frame;

  // Frame image in transmit order: slot 0 occupies the top SLOT_W bits, each
  // sample is left-aligned in its slot and the remaining slot bits are zero.
  for (genvar s = 0; s < CHANNELS; s++) begin : g_slot
    assign frame[F-1-s*SLOT_W -: SLOT_W] =
      SLOT_W'({buf_q[s*DATA_W +: DATA_W], {SLOT_W{1'b0}}} >> DATA_W);
  end

  always_comb begin
    b_next = (b_q == B_LAST) ? '0 : b_q + bit_cnt_t'(1);
    wrap   = fall && (b_q == B_LAST);
    xfer   = s_valid && ready_q;

`ifdef I2S_TX_LJ_MODE_EN
    if (CHANNELS == 2) lr_next = (b_next < B_SLOT);
    else               lr_next = (b_next == '0);
`else
    if (CHANNELS == 2) lr_next = (b_next >= B_SLOT);
    else               lr_next = (b_next == B_LAST);
`endif

    b_d     = fall ? b_next : b_q;
    lrclk_d = fall ? lr_next : lrclk_q;

    sh_d = sh_q;
    if (fall) begin
      if (wrap) sh_d = full_q ? frame : '0;
      else      sh_d = {sh_q[F-2:0], 1'b0};
    end

    // A transfer only happens while the buffer is empty, so it never
    // collides with a frame load consuming a full buffer. If it lands on the
    // load edge of an empty buffer, the load still sees "empty" (zeros plus
    // underrun) and the new sample waits for the next frame.
    buf_d  = buf_q;
    full_d = full_q;
    if (wrap && full_q) full_d = 1'b0;
    if (xfer) begin
      buf_d  = s_data;
      full_d = 1'b1;
    end

    ready_d    = !full_d;
    underrun_d = wrap && !full_q;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      b_q        <= '0;
      lrclk_q    <= 1'b0;
      sh_q       <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      b_q        <= b_d;
      lrclk_q    <= lrclk_d;
      sh_q       <= sh_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef I2S_TX_LJ_MODE_EN
  // Left-justified: the MSB of the shift register drives the pin directly.
  assign tx_sd = sh_q[F-1];
`else
  // I2S / DSP-A: data lags the word-select edge by one SCLK.
  logic sd_q, sd_d;

  always_comb begin
    sd_d = fall ? sh_q[F-1] : sd_q;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) sd_q <= 1'b0;
    else         sd_q <= sd_d;
  end

  assign tx_sd = sd_q;
`endif

  assign s_ready  = ready_q;
  assign tx_lrclk = lrclk_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_tdm.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_tdm
// Bench for i2s_tx_tdm: a default stereo instance and a 4-channel TDM
// instance share clk and reset. All timing is counted in clk cycles after
// reset release (cyc = number of clk rising edges since release, sampled on
// the following falling edge). With defaults an SCLK fall happens every 32
// clks, so fall m lands at cyc 32*m and leaves the bit counter at m mod F.
// -----------------------------------------------------------------------------
module tb_i2s_tx_tdm;

`ifdef I2S_TX_LJ_MODE_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  // stereo instance
  logic [47:0] s_data;
  logic        s_valid;
  logic        s_ready, tx_mclk, tx_sclk, tx_lrclk, tx_sd, underrun;

  // TDM instance
  logic [95:0] t_data;
  logic        t_valid;
  logic        t_ready, t_mclk, t_sclk, t_lrclk, t_sd, t_underrun;

  i2s_tx_tdm dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .tx_mclk  (tx_mclk),
    .tx_sclk  (tx_sclk),
    .tx_lrclk (tx_lrclk),
    .tx_sd    (tx_sd),
    .underrun (underrun)
  );

  i2s_tx_tdm #(.CHANNELS(4)) dut_tdm (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_data   (t_data),
    .s_valid  (t_valid),
    .s_ready  (t_ready),
    .tx_mclk  (t_mclk),
    .tx_sclk  (t_sclk),
    .tx_lrclk (t_lrclk),
    .tx_sd    (t_sd),
    .underrun (t_underrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // frames expected on the wire, frame index 0 = first frame after reset
  logic [95:0] frm [4];

  // scoreboard for s_ready pulse cycles
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // idle-run vector table: expected {mclk, sclk, lrclk, ready, underrun, sd}
  typedef struct {
    int         cyc;
    logic [5:0] exp;
  } idle_vec_t;
  idle_vec_t idle_tab [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Asserts reset between clk edges (so the clear must be asynchronous),
  // holds it for 'hold' clks and releases it on a falling edge.
  task automatic apply_reset(input int hold);
    @(negedge clk);
    reset_n = 1'b1;
    s_valid = 1'b0;
    t_valid = 1'b0;
    s_data  = '0;
    t_data  = '0;
    #1;
    chk("rst_async_outs", {20'd0, s_ready, tx_mclk, tx_sclk, tx_lrclk, tx_sd, underrun,
                           t_ready, t_mclk, t_sclk, t_lrclk, t_sd, t_underrun}, 32'd0);
    repeat (hold) @(negedge clk);
    chk("rst_hold_outs", {20'd0, s_ready, tx_mclk, tx_sclk, tx_lrclk, tx_sd, underrun,
                          t_ready, t_mclk, t_sclk, t_lrclk, t_sd, t_underrun}, 32'd0);
    reset_n = 1'b0;
    cyc     = 0;
  endtask

  // reference model
  function automatic logic exp_bit(input logic [95:0] fr, input int k);
    int s, kk;
    logic [6:0] idx;
    s  = k / 32;
    kk = k % 32;
    if (kk >= 24) return 1'b0;
    idx = 7'(s * 24 + 23 - kk);
    return fr[idx];
  endfunction

  function automatic logic exp_sd(input int m, input int nch);
    int f, b, fi;
    f  = nch * 32;
    b  = m % f;
    fi = m / f;
    if (LJ) return exp_bit(frm[fi], b);
    if (b == 0) return 1'b0;  // last bit of the previous frame is slot padding
    return exp_bit(frm[fi], b - 1);
  endfunction

  function automatic logic exp_lr(input int m, input int nch);
    int f, b;
    f = nch * 32;
    b = m % f;
    if (nch == 2) return LJ ? (b < 32) : (b >= 32);
    return LJ ? (b == 0) : (b == f - 1);
  endfunction

  function automatic logic [47:0] samp(input int i);
    return {24'h500000 + 24'(i * 16), 24'hA00000 + 24'(i)};
  endfunction

  // Walks two idle frames after a reset release, comparing table rows and
  // collecting whole-run statistics for the stereo instance.
  task automatic run_idle_table(input string tag);
    int ti, sd_hi, ur, lr_hi;
    logic [5:0] e;
    ti = 0; sd_hi = 0; ur = 0; lr_hi = 0;
    while (cyc < 4100) begin
      @(negedge clk);
      cyc++;
      if (tx_sd) sd_hi++;
      if (underrun) ur++;
      if (cyc >= 2048 && cyc <= 4095 && tx_lrclk) lr_hi++;
      if (ti < 15 && idle_tab[ti].cyc == cyc) begin
        e = idle_tab[ti].exp;
        if (LJ && cyc >= 32) e = e ^ 6'b001000;
        chk($sformatf("%s_row%0d", tag, ti),
            {26'd0, tx_mclk, tx_sclk, tx_lrclk, s_ready, underrun, tx_sd}, {26'd0, e});
        ti++;
      end
    end
    chk({tag, "_sd_quiet"}, sd_hi, 0);
    chk({tag, "_underrun_cnt"}, ur, 2);
    chk({tag, "_lrclk_duty"}, lr_hi, 1024);
  endtask

  initial begin
    int acc, idx, ur;

    idle_tab[0]  = '{cyc: 1,    exp: 6'b000100};
    idle_tab[1]  = '{cyc: 3,    exp: 6'b000100};
    idle_tab[2]  = '{cyc: 4,    exp: 6'b100100};
    idle_tab[3]  = '{cyc: 7,    exp: 6'b100100};
    idle_tab[4]  = '{cyc: 8,    exp: 6'b000100};
    idle_tab[5]  = '{cyc: 15,   exp: 6'b100100};
    idle_tab[6]  = '{cyc: 16,   exp: 6'b010100};
    idle_tab[7]  = '{cyc: 31,   exp: 6'b110100};
    idle_tab[8]  = '{cyc: 32,   exp: 6'b000100};
    idle_tab[9]  = '{cyc: 1023, exp: 6'b110100};
    idle_tab[10] = '{cyc: 1024, exp: 6'b001100};
    idle_tab[11] = '{cyc: 2047, exp: 6'b111100};
    idle_tab[12] = '{cyc: 2048, exp: 6'b000110};
    idle_tab[13] = '{cyc: 2049, exp: 6'b000100};
    idle_tab[14] = '{cyc: 4096, exp: 6'b000110};

    s_data = '0; s_valid = 1'b0;
    t_data = '0; t_valid = 1'b0;
    for (int i = 0; i < 4; i++) frm[i] = '0;

    // ---- defaults, no input ----
    apply_reset(4);
    run_idle_table("idle");

    // ---- stereo data ----
    apply_reset(2);
    frm[1] = {48'd0, 24'h123456, 24'hABCDEF};
    step_to(5);
    s_data  = {24'h123456, 24'hABCDEF};
    s_valid = 1'b1;
    step_to(6);
    s_valid = 1'b0;
    chk("st_ready_drop", s_ready, 1'b0);
    step_to(2047);
    chk("st_ready_held", s_ready, 1'b0);
    for (int m = 64; m <= 129; m++) begin
      step_to(32 * m);
      chk($sformatf("st_sd_m%0d", m), tx_sd, exp_sd(m, 2));
      chk($sformatf("st_lr_m%0d", m), tx_lrclk, exp_lr(m, 2));
      if (m == 64) begin
        chk("st_no_underrun", underrun, 1'b0);
        chk("st_ready_back", s_ready, 1'b1);
      end
      if (m == 128) chk("st_underrun_f2", underrun, 1'b1);
    end

    // ---- back-pressure: s_valid held high ----
    apply_reset(2);
    frm[0] = '0;
    frm[1] = {48'd0, samp(0)};
    frm[2] = {48'd0, samp(1)};
    frm[3] = {48'd0, samp(2)};
    s_valid = 1'b1;
    s_data  = samp(0);
    acc = 0; idx = 0; ur = 0;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2048);
    exp_q.push_back(16'd4096);
    exp_q.push_back(16'd6144);
    while (cyc < 6400) begin
      @(negedge clk);
      cyc++;
      if (acc != 0) begin
        idx++;
        s_data = samp(idx);
      end
      acc = s_ready ? 1 : 0;
      if (s_ready) got_q.push_back(16'(cyc));
      if (underrun) ur++;
      if (cyc >= 2048 && (cyc % 32) == 0) begin
        chk($sformatf("bp_sd_m%0d", cyc / 32), tx_sd, exp_sd(cyc / 32, 2));
        chk($sformatf("bp_lr_m%0d", cyc / 32), tx_lrclk, exp_lr(cyc / 32, 2));
      end
    end
    s_valid = 1'b0;
    chk("bp_ready_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk("bp_ready_cyc", {16'd0, got_q.pop_front()}, {16'd0, exp_q.pop_front()});
    end
    chk("bp_underrun", ur, 0);

    // ---- reset mid-frame ----
    apply_reset(2);
    for (int i = 0; i < 4; i++) frm[i] = '0;
    s_data = samp(7);
    step_to(3);
    s_valid = 1'b1;
    step_to(4);
    s_valid = 1'b0;
    step_to(1300);
    chk("pre_rst_sclk", tx_sclk, 1'b1);
    chk("pre_rst_lr", tx_lrclk, exp_lr(40, 2));
    apply_reset(3);
    run_idle_table("mid_rst");

    // ---- TDM, 4 channels ----
    apply_reset(2);
    for (int i = 0; i < 4; i++) frm[i] = '0;
    frm[1] = {24'h000001, 24'h000000, 24'h7FFFFF, 24'h800001};
    step_to(5);
    t_data  = frm[1];
    t_valid = 1'b1;
    step_to(6);
    t_valid = 1'b0;
    chk("tdm_ready_drop", t_ready, 1'b0);
    for (int m = 120; m <= 260; m++) begin
      step_to(32 * m);
      chk($sformatf("tdm_sd_m%0d", m), t_sd, exp_sd(m, 4));
      chk($sformatf("tdm_lr_m%0d", m), t_lrclk, exp_lr(m, 4));
      if (m == 128) chk("tdm_no_underrun", t_underrun, 1'b0);
      if (m == 256) chk("tdm_underrun_f2", t_underrun, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_tdm.md
Name: i2s_tx_tdm

Overview:
- Parametrised I2S/TDM transmitter. Successor to the fixed-rate clock generator in the i2s top level.
- Derives MCLK, SCLK and LRCLK/frame-sync from the 100 MHz system clock.
- Accepts one multi-channel sample frame per audio frame over a valid/ready handshake and serialises it onto tx_sd.
- Sits between the audio source (tone generator or FIFO) and the DAC pins.

Parameters:
- MCLK_DIV, 8: clk cycles per MCLK period; even, >=2. Default gives 12.5 MHz.
- SCLK_RATIO, 4: MCLK periods per SCLK period; >=1. Default gives 3.125 MHz.
- DATA_W, 24: sample width in bits.
- SLOT_W, 32: SCLK periods per channel slot; >= DATA_W.
- CHANNELS, 2: slots per frame, >=2. 2 means stereo I2S; >2 means TDM.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: reset_n, asynchronous, active-high.
- s_data, in, CHANNELS*DATA_W: channel 0 in the LSBs, each sample two's complement.
- s_valid, in, 1: s_data valid.
- s_ready, out, 1: holding buffer empty.
- tx_mclk, out, 1: master clock.
- tx_sclk, out, 1: bit clock.
- tx_lrclk, out, 1: word select (stereo) or frame sync (TDM).
- tx_sd, out, 1: serial data.
- underrun, out, 1: one-clk pulse when a frame starts with no sample available.

Behaviour:
- Reset values, while reset_n=1: all outputs 0; all counters 0; holding buffer empty; shift register 0.
- s_ready goes 1 on the first clk edge after release.
- Clocks, all registered from one clk-domain counter:
  - tx_mclk toggles every MCLK_DIV/2 clk cycles.
  - tx_sclk toggles every H = SCLK_RATIO*MCLK_DIV/2 clk cycles and starts low.
  - First SCLK rise is H clks after reset release.
- Fall strobe: a one-clk internal strobe `fall` is asserted on the clk where tx_sclk goes 1->0. All data-path updates happen only on `fall`.
- Bit counter b, range 0..F-1 with F = CHANNELS*SLOT_W, increments on each `fall` and wraps F-1 -> 0.
- tx_lrclk, updated on `fall`:
  - CHANNELS==2: = (b_next >= SLOT_W), so low = channel 0 (left).
  - CHANNELS>2: = (b_next == F-1), a one-SCLK pulse preceding slot 0.
- Frame load, on the `fall` where b wraps to 0:
  - If the buffer is full: the shift register loads the frame and the buffer empties (s_ready=1 next clk).
  - Otherwise: the shift register loads all zeros and underrun pulses for exactly that clk.
- Frame layout: slot s, bit k (k=0 is the MSB) = sample_s[DATA_W-1-k] for k<DATA_W, else 0.
- Shifting: shift register shifts MSB-first on every `fall`.
- I2S one-bit delay: tx_sd = shift MSB delayed by one further `fall`. Channel 0 MSB therefore appears one SCLK after the tx_lrclk edge.
- Handshake:
  - Transfer occurs when s_valid & s_ready on a clk edge; s_ready drops the next clk.
  - s_data is captured at transfer and need not be held afterwards.
- Simultaneous transfer and load on the same clk: the load uses the old buffer contents. If the buffer was empty, the new sample is buffered for the next frame and underrun still pulses.
- First frame after reset always outputs zeros.
- Reset mid-frame: all state clears immediately; no partial-frame recovery.

Optional Feature:
- Macro: I2S_TX_LJ_MODE_EN.
- Defined: left-justified mode. The one-bit delay flop is removed, so channel 0 MSB is driven on the same `fall` as the tx_lrclk edge.
  - Stereo tx_lrclk polarity inverts: high = channel 0.
  - TDM frame-sync pulse moves to b_next == 0.
- Undefined: standard I2S/DSP-A timing as in Behaviour.

Decomposition:
- Package i2s_pkg holds:
  - localparams for defaults;
  - function frame_bits(CHANNELS, SLOT_W);
  - typedef of the bit-counter width via $clog2.
- Sub-module i2s_clkgen:
  - produces tx_mclk, tx_sclk and the `fall` strobe from MCLK_DIV and SCLK_RATIO;
  - reused by a future receiver.

Test Plan:
- Defaults, no input: tx_mclk period 80 ns; tx_sclk period 320 ns; tx_lrclk period 20.48 us with 50% duty; underrun pulses once per frame; tx_sd stays 0.
- Stereo data: push {24'h123456 (right), 24'hABCDEF (left)} before the first wrap. Second frame shows tx_sd = ABCDEF MSB-first starting one SCLK after tx_lrclk falls, then 8 zeros, then 123456 after tx_lrclk rises. No underrun in that frame.
- Back-pressure: hold s_valid=1 continuously. s_ready pulses exactly once per frame, one clk after the wrap `fall`; consecutive samples appear in consecutive frames.
- TDM: CHANNELS=4, slots 0..3 = 24'h800001, 24'h7FFFFF, 0, 24'h000001. tx_lrclk high for one SCLK before slot 0; each slot is 32 SCLKs; bit patterns match.
- Reset mid-frame: assert reset_n at b=40 for 3 clks. All outputs read 0 during reset; after release, timing restarts from b=0 and the first frame is zero.
- With I2S_TX_LJ_MODE_EN: left MSB coincides with the tx_lrclk rising edge; the stereo data pattern is otherwise identical to the stereo data scenario.
